elevator_call_scheduler: RTL and testbench

Upstream stage of the elevator floor controller. Latches hall and car call buttons into a pending-call register and runs a SCAN (elevator-algorithm) state machine that picks one target floor at a time. It drives the controller's requested-floor input and consumes the controller's current-floor and door status to detect arrival, hold a dwell time and retire served calls.

---
 rtl/elevator_pkg.sv | 7 +
 rtl/elevator_call_scheduler_floor_search.sv | 33 +++
 rtl/elevator_call_scheduler.sv | 88 ++++++++
 tb/tb_elevator_call_scheduler.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// elevator_pkg: shared floor-count, floor type and scheduler state encoding.
package elevator_pkg;
  localparam int NUM_FLOORS = 16;
  localparam int FLOOR_W = 5;
  typedef logic [FLOOR_W-1:0] floor_t;
  typedef enum logic [1:0] {IDLE, UP, DOWN, DWELL} sched_state_t;
endpackage

// File: rtl/elevator_call_scheduler_floor_search.sv
// floor_search: nearest pending call above and below the car, plus a hit at the car's floor.
module floor_search
  import elevator_pkg::*;
(
  input  logic [NUM_FLOORS-1:0] pending,
  input  floor_t                cur_floor,
  output logic                  up_hit,
  output floor_t                up_floor,
  output logic                  dn_hit,
  output floor_t                dn_floor,
  output logic                  here_hit
);
  always_comb begin
    up_hit = 1'b0;
    up_floor = '0;
    dn_hit = 1'b0;
    dn_floor = '0;
    here_hit = 1'b0;
    // Scanning downward leaves the lowest hit above; scanning upward leaves the highest hit below.
    for (int k = NUM_FLOORS - 1; k >= 0; k--)
      if (pending[k] && FLOOR_W'(k) > cur_floor) begin
        up_hit = 1'b1;
        up_floor = FLOOR_W'(k);
      end
    for (int k = 0; k < NUM_FLOORS; k++) begin
      if (pending[k] && FLOOR_W'(k) < cur_floor) begin
        dn_hit = 1'b1;
        dn_floor = FLOOR_W'(k);
      end
      if (pending[k] && FLOOR_W'(k) == cur_floor) here_hit = 1'b1;
    end
  end
endmodule

// File: rtl/elevator_call_scheduler.sv
// elevator_call_scheduler: latches call buttons and runs a SCAN sweep choosing one target floor at a time.
module elevator_call_scheduler
  import elevator_pkg::*;
#(
  parameter int DWELL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  floor_t                cur_floor,
  input  logic                  door_open,
  output floor_t                target_floor,
  output logic                  target_valid,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  dir_down,
  output logic                  dwell
);
  localparam int CW = $clog2(DWELL_CYCLES + 1);
  sched_state_t state_q, state_d, seek;
  logic [NUM_FLOORS-1:0] pending_q, pending_d, cur_oh;
  floor_t target_q, target_d, up_floor, dn_floor;
  logic tv_q, tv_d, up_q, up_d, dn_q, dn_d, dwell_q, dwell_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic up_hit, dn_hit, here_hit, arrive, go_up, entry;
  floor_search u_search (
    .pending  (pending_q),
    .cur_floor(cur_floor),
    .up_hit   (up_hit),
    .up_floor (up_floor),
    .dn_hit   (dn_hit),
    .dn_floor (dn_floor),
    .here_hit (here_hit)
  );
  always_comb begin
    cur_oh = '0;
    for (int k = 0; k < NUM_FLOORS; k++) cur_oh[k] = FLOOR_W'(k) == cur_floor;
    arrive = tv_q && cur_floor == target_q && door_open;
    go_up = up_hit && (!dn_hit || (up_floor - cur_floor) <= (cur_floor - dn_floor));
    seek = go_up ? UP : dn_hit ? DOWN : IDLE;
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = here_hit ? DWELL : seek;
      UP:    state_d = arrive ? DWELL : up_hit ? UP : IDLE;
      DOWN:  state_d = arrive ? DWELL : dn_hit ? DOWN : IDLE;
      DWELL: if (cnt_q == '0)
               state_d = up_q ? (up_hit ? UP : dn_hit ? DOWN : IDLE)
                       : dn_q ? (dn_hit ? DOWN : up_hit ? UP : IDLE) : seek;
    endcase
    entry = state_d == DWELL && state_q != DWELL;
    cnt_d = entry ? CW'(DWELL_CYCLES - 1) : (state_q == DWELL && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    // The open door already serves the current floor, so its button is masked while dwelling.
    pending_d = (pending_q | (call_req & ~({NUM_FLOORS{state_q == DWELL}} & cur_oh)))
              & ~({NUM_FLOORS{entry}} & cur_oh);
    tv_d = state_d == UP || state_d == DOWN;
    up_d = state_d == UP || (state_d == DWELL && up_q);
    dn_d = state_d == DOWN || (state_d == DWELL && dn_q);
    dwell_d = state_d == DWELL;
    target_d = state_d == UP ? up_floor : state_d == DOWN ? dn_floor : target_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pending_q <= '0;
      target_q <= '0;
      tv_q <= 1'b0;
      up_q <= 1'b0;
      dn_q <= 1'b0;
      dwell_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      target_q <= target_d;
      tv_q <= tv_d;
      up_q <= up_d;
      dn_q <= dn_d;
      dwell_q <= dwell_d;
      cnt_q <= cnt_d;
    end
  end
  assign target_floor = target_q;
  assign target_valid = tv_q;
  assign pending = pending_q;
  assign dir_up = up_q;
  assign dir_down = dn_q;
  assign dwell = dwell_q;
endmodule

// File: tb/tb_elevator_call_scheduler.sv
// tb_elevator_call_scheduler: directed vector table plus hand-written sweep sequences.
module tb_elevator_call_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] call_req = '0;
  logic [4:0] cur_floor = '0;
  logic door_open = 1'b0;
  logic [4:0] target_floor;
  logic target_valid, dir_up, dir_down, dwell;
  logic [15:0] pending;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic rst;
    logic [15:0] call;
    logic [4:0] cur;
    logic door;
    logic [4:0] tf;
    logic tv;
    logic [15:0] pd;
    logic up, dn, dw;
  } vec_t;
  vec_t vec [12];
  elevator_call_scheduler dut (
    .clk(clk), .reset(reset), .call_req(call_req), .cur_floor(cur_floor), .door_open(door_open),
    .target_floor(target_floor), .target_valid(target_valid), .pending(pending),
    .dir_up(dir_up), .dir_down(dir_down), .dwell(dwell)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [15:0] c, input logic [4:0] f, input logic d);
    call_req = c;
    cur_floor = f;
    door_open = d;
    step();
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic expect_o(input string nm, input logic [4:0] tf, input logic tv, input logic [15:0] pd,
                          input logic u, input logic d, input logic w);
    chk({nm, ".target_floor"}, 32'(target_floor), 32'(tf));
    chk({nm, ".target_valid"}, 32'(target_valid), 32'(tv));
    chk({nm, ".pending"}, 32'(pending), 32'(pd));
    chk({nm, ".dir_up"}, 32'(dir_up), 32'(u));
    chk({nm, ".dir_down"}, 32'(dir_down), 32'(d));
    chk({nm, ".dwell"}, 32'(dwell), 32'(w));
  endtask
  task automatic do_reset(input logic [4:0] f);
    reset = 1'b1;
    drive('0, f, 1'b0);
    reset = 1'b0;
  endtask
  initial begin
    vec[0]  = '{1'b1, 16'hFFFF, 5'd0, 1'b0, 5'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vec[1]  = '{1'b1, 16'hFFFF, 5'd0, 1'b0, 5'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vec[2]  = '{1'b0, 16'hFFFF, 5'd0, 1'b0, 5'd0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vec[3]  = '{1'b1, 16'h0000, 5'd0, 1'b0, 5'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vec[4]  = '{1'b0, 16'h0020, 5'd0, 1'b0, 5'd0, 1'b0, 16'h0020, 1'b0, 1'b0, 1'b0};
    vec[5]  = '{1'b0, 16'h0000, 5'd0, 1'b0, 5'd5, 1'b1, 16'h0020, 1'b1, 1'b0, 1'b0};
    vec[6]  = '{1'b0, 16'h0000, 5'd0, 1'b0, 5'd5, 1'b1, 16'h0020, 1'b1, 1'b0, 1'b0};
    vec[7]  = '{1'b0, 16'h0000, 5'd5, 1'b1, 5'd5, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vec[8]  = '{1'b0, 16'h0020, 5'd5, 1'b1, 5'd5, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vec[9]  = '{1'b0, 16'h0000, 5'd5, 1'b1, 5'd5, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vec[10] = '{1'b0, 16'h0000, 5'd5, 1'b1, 5'd5, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vec[11] = '{1'b0, 16'h0000, 5'd5, 1'b1, 5'd5, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      reset = vec[i].rst;
      drive(vec[i].call, vec[i].cur, vec[i].door);
      expect_o($sformatf("vec%0d", i), vec[i].tf, vec[i].tv, vec[i].pd, vec[i].up, vec[i].dn, vec[i].dw);
    end
    // Nearer call preempts an upward sweep, then the sweep resumes after dwelling.
    do_reset(5'd2);
    drive(16'h0200, 5'd2, 1'b0);
    drive(16'h0000, 5'd2, 1'b0);
    expect_o("sweep9", 5'd9, 1'b1, 16'h0200, 1'b1, 1'b0, 1'b0);
    drive(16'h0010, 5'd2, 1'b0);
    expect_o("press4", 5'd9, 1'b1, 16'h0210, 1'b1, 1'b0, 1'b0);
    drive(16'h0000, 5'd2, 1'b0);
    expect_o("preempt4", 5'd4, 1'b1, 16'h0210, 1'b1, 1'b0, 1'b0);
    drive(16'h0000, 5'd4, 1'b1);
    expect_o("dwell4", 5'd4, 1'b0, 16'h0200, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(16'h0000, 5'd4, 1'b1);
    chk("dwell4_last", 32'(dwell), 32'd1);
    drive(16'h0000, 5'd4, 1'b1);
    expect_o("resume9", 5'd9, 1'b1, 16'h0200, 1'b1, 1'b0, 1'b0);
    // Direction kept after a downward dwell at 6.
    do_reset(5'd8);
    drive(16'h0040, 5'd8, 1'b0);
    drive(16'h0000, 5'd8, 1'b0);
    expect_o("down6", 5'd6, 1'b1, 16'h0040, 1'b0, 1'b1, 1'b0);
    drive(16'h0000, 5'd6, 1'b1);
    drive(16'h0408, 5'd6, 1'b1);
    drive(16'h0000, 5'd6, 1'b1);
    drive(16'h0000, 5'd6, 1'b1);
    drive(16'h0000, 5'd6, 1'b1);
    expect_o("keep_down", 5'd3, 1'b1, 16'h0408, 1'b0, 1'b1, 1'b0);
    // Direction kept after an upward dwell at 6.
    do_reset(5'd4);
    drive(16'h0040, 5'd4, 1'b0);
    drive(16'h0000, 5'd4, 1'b0);
    drive(16'h0000, 5'd6, 1'b1);
    drive(16'h0408, 5'd6, 1'b1);
    drive(16'h0000, 5'd6, 1'b1);
    drive(16'h0000, 5'd6, 1'b1);
    drive(16'h0000, 5'd6, 1'b1);
    expect_o("keep_up", 5'd10, 1'b1, 16'h0408, 1'b1, 1'b0, 1'b0);
    // Equal distance from idle goes up; strictly nearer below goes down.
    do_reset(5'd7);
    drive(16'h0220, 5'd7, 1'b0);
    drive(16'h0000, 5'd7, 1'b0);
    expect_o("tie_up", 5'd9, 1'b1, 16'h0220, 1'b1, 1'b0, 1'b0);
    do_reset(5'd7);
    drive(16'h0420, 5'd7, 1'b0);
    drive(16'h0000, 5'd7, 1'b0);
    expect_o("near_dn", 5'd5, 1'b1, 16'h0420, 1'b0, 1'b1, 1'b0);
    // Held button at the car's floor: clear wins on entry and is ignored while dwelling.
    do_reset(5'd6);
    drive(16'h0040, 5'd6, 1'b0);
    chk("here_pend", 32'(pending), 32'h0040);
    drive(16'h0040, 5'd6, 1'b0);
    expect_o("here_entry", 5'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    drive(16'h0040, 5'd6, 1'b1);
    expect_o("here_masked", 5'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    // Out-of-range car floor sits above every floor.
    do_reset(5'd20);
    drive(16'h0008, 5'd20, 1'b0);
    drive(16'h0000, 5'd20, 1'b0);
    expect_o("above_all", 5'd3, 1'b1, 16'h0008, 1'b0, 1'b1, 1'b0);
    // Reset mid-sweep discards everything.
    do_reset(5'd0);
    drive(16'h0100, 5'd0, 1'b0);
    drive(16'h0000, 5'd0, 1'b0);
    expect_o("pre_reset", 5'd8, 1'b1, 16'h0100, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    drive(16'h0000, 5'd0, 1'b0);
    expect_o("mid_reset", 5'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    drive(16'h0000, 5'd0, 1'b0);
    chk("post_reset_tv", 32'(target_valid), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
